// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake direction input block.
// Heading encoding: N=00, E=01, S=10, W=11. Opposite headings differ only in bit 1.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_N     = 2'b00;
    localparam dir_t DIR_E     = 2'b01;
    localparam dir_t DIR_S     = 2'b10;
    localparam dir_t DIR_W     = 2'b11;
    localparam dir_t DIR_RESET = DIR_E;

    // Heading pointing the other way.
    function automatic dir_t dir_opposite(input dir_t d);
        return d ^ 2'b10;
    endfunction

    // One-hot decode, bit order {W, S, E, N}.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        return 4'b0001 << d;
    endfunction

    // A turn is only meaningful if it is neither straight ahead nor a reversal.
    function automatic logic dir_accept(input dir_t evt, input dir_t ref_dir);
        return (evt != ref_dir) && (evt != dir_opposite(ref_dir));
    endfunction

endpackage

// File: rtl/snake_direction_input_if.sv
// Button/tick inputs and heading outputs of snake_direction_input.
// master: the side that drives the buttons and the movement tick.
// slave : the direction block itself.
interface snake_direction_input_if;
    logic       iBtnNorth;
    logic       iBtnEast;
    logic       iBtnSouth;
    logic       iBtnWest;
    logic       iTick;
    logic [1:0] oDirection;
    logic       oNorth;
    logic       oEast;
    logic       oSouth;
    logic       oWest;
    logic       oTurnPulse;

    modport master (
        output iBtnNorth, iBtnEast, iBtnSouth, iBtnWest, iTick,
        input  oDirection, oNorth, oEast, oSouth, oWest, oTurnPulse
    );

    modport slave (
        input  iBtnNorth, iBtnEast, iBtnSouth, iBtnWest, iTick,
        output oDirection, oNorth, oEast, oSouth, oWest, oTurnPulse
    );
endinterface

// File: rtl/snake_btn_debounce.sv
// One push-button conditioner: 2-FF synchroniser, stability counter and
// single-cycle press (0->1 of the debounced level) detector. Release is silent.
module snake_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 320000,
    parameter int CNT_W           = 19
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreement cycles; flip the level once it has lasted long enough.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    // Synchroniser, debounce state and registered press pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/snake_direction_input.sv
// Snake heading controller: debounces four direction buttons, rejects
// reversals and holds the requested turn until the movement tick commits it.
// Optional macro SNAKE_DIR_QUEUE_EN: pending turn becomes a 2-entry FIFO
// instead of a single overwrite register.
module snake_direction_input
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 320000,
    parameter int CNT_W           = 19
) (
    input  logic                         Clock,
    input  logic                         Reset,
    snake_direction_input_if.slave       bus
);

    logic press_n, press_e, press_s, press_w;

    snake_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_n (
        .clk_i(Clock), .rst_ni(Reset), .btn_i(bus.iBtnNorth), .press_o(press_n));
    snake_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_e (
        .clk_i(Clock), .rst_ni(Reset), .btn_i(bus.iBtnEast),  .press_o(press_e));
    snake_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_s (
        .clk_i(Clock), .rst_ni(Reset), .btn_i(bus.iBtnSouth), .press_o(press_s));
    snake_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_w (
        .clk_i(Clock), .rst_ni(Reset), .btn_i(bus.iBtnWest),  .press_o(press_w));

    logic       evt_vld;
    dir_t       evt_dir;
    dir_t       dir_q, dir_d;
    logic [3:0] onehot_q;
    logic       turn_q;

    // Collapse simultaneous presses to one event, priority N > S > E > W.
    always_comb begin
        evt_vld = press_n | press_s | press_e | press_w;
        evt_dir = DIR_N;
        if (press_n)      evt_dir = DIR_N;
        else if (press_s) evt_dir = DIR_S;
        else if (press_e) evt_dir = DIR_E;
        else if (press_w) evt_dir = DIR_W;
    end

`ifdef SNAKE_DIR_QUEUE_EN
    dir_t       q0_q, q0_d, q1_q, q1_d;
    logic [1:0] cnt_q, cnt_d;
    dir_t       ref_dir;
    logic       acc;
    logic [1:0] cnt_pop;

    // FIFO of pending turns: tick pops the head into the heading, accepted events push.
    always_comb begin
        dir_d   = dir_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        cnt_pop = cnt_q;
        ref_dir = (cnt_q == 2'd2) ? q1_q : (cnt_q == 2'd1) ? q0_q : dir_q;
        acc     = evt_vld && dir_accept(evt_dir, ref_dir);
        if (bus.iTick && cnt_q != 2'd0) begin
            dir_d   = q0_q;
            q0_d    = q1_q;
            cnt_pop = cnt_q - 2'd1;
            cnt_d   = cnt_pop;
            if (acc) begin
                if (cnt_pop == 2'd0) q0_d = evt_dir;
                else                 q1_d = evt_dir;
                cnt_d = cnt_pop + 2'd1;
            end
        end else if (bus.iTick) begin
            if (acc) dir_d = evt_dir;
        end else if (acc && cnt_q != 2'd2) begin
            if (cnt_q == 2'd0) q0_d = evt_dir;
            else               q1_d = evt_dir;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Pending-turn FIFO storage.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q0_q  <= DIR_RESET;
            q1_q  <= DIR_RESET;
            cnt_q <= 2'd0;
        end else begin
            q0_q  <= q0_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_d;
        end
    end
`else
    dir_t pend_q, pend_d;
    logic pvld_q, pvld_d;

    // Single pending turn, overwritten by any later accepted event.
    always_comb begin
        dir_d  = dir_q;
        pend_d = pend_q;
        pvld_d = pvld_q;
        if (bus.iTick && pvld_q) begin
            dir_d  = pend_q;
            pvld_d = 1'b0;
            if (evt_vld && dir_accept(evt_dir, pend_q)) begin
                pend_d = evt_dir;
                pvld_d = 1'b1;
            end
        end else if (bus.iTick) begin
            if (evt_vld && dir_accept(evt_dir, dir_q)) dir_d = evt_dir;
        end else if (evt_vld && dir_accept(evt_dir, pvld_q ? pend_q : dir_q)) begin
            pend_d = evt_dir;
            pvld_d = 1'b1;
        end
    end

    // Pending-turn register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pend_q <= DIR_RESET;
            pvld_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            pvld_q <= pvld_d;
        end
    end
`endif

    // Committed heading, its one-hot decode and the turn-notification pulse.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            dir_q    <= DIR_RESET;
            onehot_q <= dir_onehot(DIR_RESET);
            turn_q   <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            onehot_q <= dir_onehot(dir_d);
            turn_q   <= (dir_d != dir_q);
        end
    end

    assign bus.oDirection = dir_q;
    assign bus.oNorth     = onehot_q[0];
    assign bus.oEast      = onehot_q[1];
    assign bus.oSouth     = onehot_q[2];
    assign bus.oWest      = onehot_q[3];
    assign bus.oTurnPulse = turn_q;

endmodule

// File: tb/tb_snake_direction_input.sv
// Scoreboard bench for snake_direction_input with DEBOUNCE_CYCLES=4.
// Honours SNAKE_DIR_QUEUE_EN for the overwrite-vs-queue scenario.
module tb_snake_direction_input;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    snake_direction_input_if bus ();

    snake_direction_input #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string      name;
        logic [1:0] dir;
        logic       turn;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] turn_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic logic [3:0] model_onehot(input logic [1:0] d);
        case (d)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: state snapshots and turn pulses are compared on the falling edge.
    always @(negedge Clock) begin
        logic [3:0] oh;
        oh = {bus.oWest, bus.oSouth, bus.oEast, bus.oNorth};
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, "_dir"},  32'(bus.oDirection), 32'(e.dir));
            chk({e.name, "_oh"},   32'(oh),             32'(model_onehot(e.dir)));
            chk({e.name, "_turn"}, 32'(bus.oTurnPulse), 32'(e.turn));
        end
        if (Reset && bus.oTurnPulse) begin
            if (turn_q.size() == 0) begin
                chk("unexpected_turn", 32'(bus.oDirection), 32'hFFFF_FFFF);
            end else begin
                logic [1:0] d;
                d = turn_q.pop_front();
                chk("turn_dir", 32'(bus.oDirection), 32'(d));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [1:0] d);
        exp_t e;
        e.name = name;
        e.dir  = d;
        e.turn = 1'b0;
        exp_q.push_back(e);
        cycles(1);
    endtask

    // mask bits {W,S,E,N}
    task automatic press(input logic [3:0] mask, input int hold);
        bus.iBtnNorth = mask[0];
        bus.iBtnEast  = mask[1];
        bus.iBtnSouth = mask[2];
        bus.iBtnWest  = mask[3];
        cycles(hold);
        bus.iBtnNorth = 1'b0;
        bus.iBtnEast  = 1'b0;
        bus.iBtnSouth = 1'b0;
        bus.iBtnWest  = 1'b0;
        cycles(10);
    endtask

    task automatic tick(input logic commit, input logic [1:0] d);
        if (commit) turn_q.push_back(d);
        bus.iTick = 1'b1;
        cycles(1);
        bus.iTick = 1'b0;
        cycles(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iBtnNorth = 1'b0;
        bus.iBtnEast  = 1'b0;
        bus.iBtnSouth = 1'b0;
        bus.iBtnWest  = 1'b0;
        bus.iTick     = 1'b0;
        Reset         = 1'b0;
        cycles(4);
        expect_state("in_reset", 2'b01);
        Reset = 1'b1;
        cycles(2);
        expect_state("after_reset", 2'b01);
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b00);
        expect_state("idle_ticks", 2'b01);

        // Short glitch on North must not register.
        press(4'b0001, 3);
        tick(1'b0, 2'b00);
        expect_state("glitch", 2'b01);

        // Held North becomes pending, tick commits it.
        press(4'b0001, 10);
        tick(1'b1, 2'b00);
        expect_state("north", 2'b00);

        // Back to East, then a West reversal is refused.
        press(4'b0010, 10);
        tick(1'b1, 2'b01);
        expect_state("east", 2'b01);
        press(4'b1000, 10);
        tick(1'b0, 2'b00);
        expect_state("reversal", 2'b01);

        // North then West before any tick.
        press(4'b0001, 10);
        press(4'b1000, 10);
`ifdef SNAKE_DIR_QUEUE_EN
        tick(1'b1, 2'b00);
        expect_state("queue_first", 2'b00);
        tick(1'b1, 2'b11);
        expect_state("queue_second", 2'b11);
`else
        tick(1'b1, 2'b11);
        expect_state("overwrite", 2'b11);
`endif

        // Return to East via North.
        press(4'b0001, 10);
        tick(1'b1, 2'b00);
        press(4'b0010, 10);
        tick(1'b1, 2'b01);
        expect_state("east_again", 2'b01);

        // North and South together: North wins.
        press(4'b0101, 10);
        tick(1'b1, 2'b00);
        expect_state("priority", 2'b00);

        // Head West, queue South, then reset asynchronously mid-cycle.
        press(4'b1000, 10);
        tick(1'b1, 2'b11);
        expect_state("west", 2'b11);
        press(4'b0100, 10);
        #2;
        Reset = 1'b0;
        begin
            exp_t e;
            e.name = "async_reset";
            e.dir  = 2'b01;
            e.turn = 1'b0;
            exp_q.push_back(e);
        end
        cycles(2);
        Reset = 1'b1;
        cycles(2);
        tick(1'b0, 2'b00);
        expect_state("post_reset_tick", 2'b01);

        cycles(3);
        chk("turns_outstanding", 32'(turn_q.size()), 32'd0);
        chk("snapshots_outstanding", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
